// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer: collects WIDTH bits (MSB- or LSB-first)
// into a registered word, with a valid/ready handshake on the output and an
// overrun pulse when a completed word has to be dropped.
module serial_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             msb_first,
    input  logic             s_din,
    input  logic             s_valid,
    input  logic             clr,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             dir;
    logic [WIDTH-1:0] shifted;
    logic             done;

    // Word as it would look with the current serial bit applied
    always_comb begin
        shifted = sreg;
        if (dir) begin
            shifted = {sreg[WIDTH-2:0], s_din};
        end else begin
            shifted = {s_din, sreg[WIDTH-1:1]};
        end
    end

    assign done = (state == SHIFT) && !clr && s_valid && (cnt == CW'(WIDTH - 1));
    assign busy = (state == SHIFT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; clr wins over start and s_valid
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!clr && start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (clr || done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift register, bit counter and latched bit order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
            dir  <= 1'b0;
        end else if (clr) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (state == IDLE && start) begin
            dir  <= msb_first;
            sreg <= '0;
            cnt  <= '0;
        end else if (state == SHIFT && s_valid) begin
            if (done) begin
                sreg <= '0;
                cnt  <= '0;
            end else begin
                sreg <= shifted;
                cnt  <= cnt + CW'(1);
            end
        end
    end

    // Output word, handshake and overrun pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_dout  <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (p_valid && !p_ready) begin
                    overrun <= 1'b1;
                end else begin
                    p_dout  <= shifted;
                    p_valid <= 1'b1;
                end
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer (WIDTH = 4).
module tb_serial_deserializer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       msb_first;
    logic       s_din;
    logic       s_valid;
    logic       clr;
    logic       p_ready;
    logic [3:0] p_dout;
    logic       p_valid;
    logic       busy;
    logic       overrun;

    int total  = 0;
    int passed = 0;

    serial_deserializer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .msb_first (msb_first),
        .s_din     (s_din),
        .s_valid   (s_valid),
        .clr       (clr),
        .p_ready   (p_ready),
        .p_dout    (p_dout),
        .p_valid   (p_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        s_valid = 1'b1;
        s_din   = b;
        tick();
        s_valid = 1'b0;
        s_din   = 1'b0;
    endtask

    task automatic begin_frame(input logic order);
        start     = 1'b1;
        msb_first = order;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; msb_first = 1'b0; s_din = 1'b0;
        s_valid = 1'b0; clr = 1'b0; p_ready = 1'b0;
        #12;
        check("rst_dout",    16'(p_dout),  16'h0);
        check("rst_valid",   16'(p_valid), 16'h0);
        check("rst_busy",    16'(busy),    16'h0);
        check("rst_overrun", 16'(overrun), 16'h0);
        rst = 1'b1;
        tick();

        // MSB-first 1,1,0,1
        begin_frame(1'b1);
        check("msb_busy", 16'(busy), 16'h1);
        send(1'b1); send(1'b1); send(1'b0);
        check("msb_notyet", 16'(p_valid), 16'h0);
        send(1'b1);
        check("msb_dout",  16'(p_dout),  16'hD);
        check("msb_valid", 16'(p_valid), 16'h1);
        check("msb_idle",  16'(busy),    16'h0);
        p_ready = 1'b1; tick(); p_ready = 1'b0;
        check("msb_consumed", 16'(p_valid), 16'h0);

        // LSB-first 1,0,1,1 -> 1101
        begin_frame(1'b0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        check("lsb_dout",  16'(p_dout),  16'hD);
        check("lsb_valid", 16'(p_valid), 16'h1);
        p_ready = 1'b1; tick(); p_ready = 1'b0;

        // LSB-first 0,0,0,1 -> 1000, msb_first flipped mid-frame must be ignored
        begin_frame(1'b0);
        send(1'b0);
        msb_first = 1'b1;
        send(1'b0); send(1'b0); send(1'b1);
        check("lsb2_dout", 16'(p_dout), 16'h8);
        p_ready = 1'b1; tick(); p_ready = 1'b0;
        check("lsb2_consumed", 16'(p_valid), 16'h0);

        // Gaps of 3 idle cycles between bits 1,0,1,0 (MSB-first); start mid-frame ignored
        begin_frame(1'b1);
        send(1'b1); tick(); tick(); tick();
        send(1'b0);
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        send(1'b1); tick(); tick(); tick();
        check("gap_notyet", 16'(p_valid), 16'h0);
        check("gap_busy",   16'(busy),    16'h1);
        send(1'b0);
        check("gap_dout",  16'(p_dout),  16'hA);
        check("gap_valid", 16'(p_valid), 16'h1);
        p_ready = 1'b1; tick(); p_ready = 1'b0;
        check("gap_consumed", 16'(p_valid), 16'h0);

        // Overrun: 1101 held unconsumed, then 0110 arrives
        begin_frame(1'b1);
        send(1'b1); send(1'b1); send(1'b0); send(1'b1);
        begin_frame(1'b1);
        send(1'b0); send(1'b1); send(1'b1);
        check("ovr_before", 16'(overrun), 16'h0);
        send(1'b0);
        check("ovr_pulse", 16'(overrun), 16'h1);
        check("ovr_dout",  16'(p_dout),  16'hD);
        check("ovr_valid", 16'(p_valid), 16'h1);
        check("ovr_idle",  16'(busy),    16'h0);
        tick();
        check("ovr_once", 16'(overrun), 16'h0);

        // Completion with p_ready=1 while p_valid=1: new word loaded, no overrun
        begin_frame(1'b1);
        send(1'b0); send(1'b1); send(1'b1);
        p_ready = 1'b1;
        send(1'b0);
        p_ready = 1'b0;
        check("rdy_dout",    16'(p_dout),  16'h6);
        check("rdy_valid",   16'(p_valid), 16'h1);
        check("rdy_overrun", 16'(overrun), 16'h0);
        p_ready = 1'b1; tick(); p_ready = 1'b0;

        // Abort after 2 bits (clr beats s_valid), then full frame 0011
        begin_frame(1'b1);
        send(1'b1); send(1'b1);
        clr = 1'b1; s_valid = 1'b1; s_din = 1'b1;
        tick();
        clr = 1'b0; s_valid = 1'b0; s_din = 1'b0;
        check("clr_idle",  16'(busy),    16'h0);
        check("clr_valid", 16'(p_valid), 16'h0);
        begin_frame(1'b1);
        send(1'b0); send(1'b0); send(1'b1); send(1'b1);
        check("clr_dout", 16'(p_dout), 16'h3);

        // Asynchronous reset mid-frame
        begin_frame(1'b1);
        send(1'b1); send(1'b0);
        #3 rst = 1'b0;
        #1;
        check("arst_dout",    16'(p_dout),  16'h0);
        check("arst_valid",   16'(p_valid), 16'h0);
        check("arst_busy",    16'(busy),    16'h0);
        check("arst_overrun", 16'(overrun), 16'h0);
        #10 rst = 1'b1;
        tick();
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        check("post_rst_valid", 16'(p_valid), 16'h0);
        check("post_rst_busy",  16'(busy),    16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
